// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder: adds CHUNK bits per cycle, rippling the carry through a register.
// Optional subtract mode (input sub) when SEQ_RIPPLE_ADDER_SUBTRACT_EN is defined.
module seq_ripple_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_RIPPLE_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sub_q, sub_d;
  logic               sub_in;
  logic [WIDTH-1:0]   b_eff;
  logic [CHUNK:0]     chunk_sum;

`ifdef SEQ_RIPPLE_ADDER_SUBTRACT_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
    end
  end

  // Subtraction is a + ~b + 1: invert the latched operand and seed the carry with 1.
  always_comb begin
    b_eff     = sub_q ? ~b_q : b_q;
    chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
              + {1'b0, b_eff[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          carry_d = sub_in ? 1'b1 : cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = chunk_sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Directed self-checking bench for seq_ripple_adder (WIDTH=8/CHUNK=4 and WIDTH=CHUNK=8).
// Subtract cases run only when SEQ_RIPPLE_ADDER_SUBTRACT_EN is defined.
module tb_seq_ripple_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] sum0, sum1;
  logic       cout0, cout1, busy0, busy1, done0, done1;

  logic       sel_wide = 1'b0;
  logic [7:0] o_sum;
  logic       o_cout, o_busy, o_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_ripple_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start0),
`ifdef SEQ_RIPPLE_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .sum(sum0), .cout(cout0), .busy(busy0), .done(done0)
  );

  seq_ripple_adder #(.WIDTH(8), .CHUNK(8)) dut_w (
    .clk(clk), .rst(rst), .start(start1),
`ifdef SEQ_RIPPLE_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  always_comb begin
    o_sum  = sel_wide ? sum1  : sum0;
    o_cout = sel_wide ? cout1 : cout0;
    o_busy = sel_wide ? busy1 : busy0;
    o_done = sel_wide ? done1 : done0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, wait (bounded) for done, check latency, result and hold.
  task automatic run_op(input logic wide, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic isub, input logic [7:0] es,
                        input logic ec, input int lat, input string tag);
    int n;
    sel_wide = wide;
    a = ia; b = ib; cin = ic; sub = isub;
    if (wide) start1 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0; start1 = 1'b0;
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    n = 0;
    while (!o_done && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_sum"}, {24'd0, o_sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, o_cout}, {31'd0, ec});
    a = ~ia; b = ~ib;
    step();
    chk({tag, "_done_low"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_sum_hold"}, {24'd0, o_sum}, {24'd0, es});
    chk({tag, "_cout_hold"}, {31'd0, o_cout}, {31'd0, ec});
  endtask

  initial begin
    // reset for 2 cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_sum", {24'd0, sum0}, 32'h00);
    chk("rst_cout", {31'd0, cout0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    step();
    chk("idle_done", {31'd0, done0}, 32'd0);

    run_op(1'b0, 8'hD3, 8'h4B, 1'b0, 1'b0, 8'h1E, 1'b1, 2, "add_d3_4b");
    run_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 2, "add_0f_01");
    run_op(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2, "add_ff_cin");

    // start held high; operand changed mid-RUN
    sel_wide = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0; start0 = 1'b1;
    step();
    chk("hold_busy0", {31'd0, busy0}, 32'd1);
    a = 8'h55;
    step();
    chk("hold_done_s1", {31'd0, done0}, 32'd0);
    step();
    chk("hold_done1", {31'd0, done0}, 32'd1);
    chk("hold_sum1", {24'd0, sum0}, 32'h46);
    step();
    chk("hold_idle_done", {31'd0, done0}, 32'd0);
    chk("hold_idle_busy", {31'd0, busy0}, 32'd0);
    step();
    chk("hold_reaccept", {31'd0, busy0}, 32'd1);
    step();
    step();
    chk("hold_done2", {31'd0, done0}, 32'd1);
    chk("hold_sum2", {24'd0, sum0}, 32'h89);
    start0 = 1'b0;
    step();
    step();
    chk("hold_no_third", {31'd0, busy0 | done0}, 32'd0);

    // reset in the first RUN cycle
    a = 8'hD3; b = 8'h4B; start0 = 1'b1;
    step();
    start0 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_sum", {24'd0, sum0}, 32'h00);
    chk("abort_cout", {31'd0, cout0}, 32'd0);
    step();
    step();
    chk("abort_no_done", {31'd0, done0}, 32'd0);
    run_op(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 2, "post_abort");

    // single-chunk configuration
    run_op(1'b1, 8'hD3, 8'h4B, 1'b0, 1'b0, 8'h1E, 1'b1, 1, "w_add_d3_4b");

`ifdef SEQ_RIPPLE_ADDER_SUBTRACT_EN
    run_op(1'b0, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 2, "sub_7_5");
    run_op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 2, "sub_5_7");
    run_op(1'b0, 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 2, "sub_cin_ign");
    run_op(1'b0, 8'hD3, 8'h4B, 1'b0, 1'b0, 8'h1E, 1'b1, 2, "sub0_add");
    run_op(1'b1, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1, "w_sub_7_5");
    run_op(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1, "w_sub_5_7");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_ripple_adder.md
SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  result register.
- cout  output  1  carry-out of the MSB chunk.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; sum and cout are valid.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-006 In IDLE with start=1, the block SHALL latch a, b and cin, clear sum to 0, set the chunk index to 0, and go to RUN.
REQ-007 In IDLE with start=0, the block SHALL hold all outputs unchanged.
REQ-008 On each RUN cycle, the block SHALL compute latched A chunk + latched B chunk + the carry register at the current index, CHUNK+1 bits wide.
REQ-009 On the same cycle, the block SHALL write the low CHUNK bits into sum[idx*CHUNK +: CHUNK], store the top bit in the carry register, and increment the index.
REQ-010 After the chunk at index N-1, the block SHALL set cout to the final carry and go to DONE.
REQ-011 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-012 Latency: done SHALL be asserted in the cycle following the Nth rising edge after the edge that accepted start. For CHUNK=WIDTH this is one RUN cycle.
REQ-013 After done, sum and cout SHALL hold their values until the next start is accepted.
REQ-014 busy SHALL be 1 exactly in RUN; done SHALL be 0 outside DONE.
REQ-015 start SHALL be ignored in RUN and DONE; a start held high from acceptance through DONE SHALL produce exactly one operation.
REQ-016 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-017 During RUN, only sum chunks below the current index hold final values; sum is checked only at done.
REQ-018 Result arithmetic: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).

Reset
REQ-019 With rst=1 at a rising edge, the block SHALL go to IDLE and set sum=0, cout=0, busy=0, done=0, carry register=0 and index=0.
REQ-020 Reset SHALL take priority over start and over any state; reset during RUN or DONE SHALL abort the operation without asserting done.
REQ-021 The first start after reset is released SHALL be accepted normally.

Configuration
REQ-022 With macro SEQ_RIPPLE_ADDER_SUBTRACT_EN defined, the block SHALL add a 1-bit input port sub, latched with the operands.
REQ-023 With the macro defined and latched sub=1, the block SHALL invert latched b, force the initial carry to 1 and ignore cin, so that {cout,sum} = a - b with cout=1 meaning no borrow.
REQ-024 With the macro defined and sub=0, the block SHALL behave as in REQ-018.
REQ-025 Without the macro, the sub port SHALL be absent and the block SHALL always add.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-026 The bench SHALL cover the following directed scenarios:
- rst=1 for 2 cycles, then release -> sum=0x00, cout=0, busy=0, done=0.
- a=0xD3, b=0x4B, cin=0, start pulse -> busy for 2 cycles; done in the 2nd cycle after acceptance; sum=0x1E, cout=1; values held afterwards.
- a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0 (carry across chunks). a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- start held high continuously, a changed to 0x55 mid-RUN -> one done per accepted start; result uses the latched operands.
- rst asserted in the first RUN cycle -> no done, all outputs 0; the next start with a=0x01, b=0x02 gives sum=0x03.
- Macro defined, sub=1: a=0x07, b=0x05 -> sum=0x02, cout=1. a=0x05, b=0x07 -> sum=0xFE, cout=0. Repeat with WIDTH=CHUNK=8 -> done one cycle after acceptance.
